rr_channel_arbiter: RTL and testbench



---
 rtl/rr_channel_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_channel_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_channel_arbiter.sv
// rr_channel_arbiter
//   Round-robin arbiter and sequencer for the shared photonic channel. It
//   grants one router at a time and holds that grant until the owner signals
//   done, drops its request, or reaches the hold timeout. After every release
//   it inserts a guard interval so the waveguides can drain.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   request        per-router request_to_send (level)
//   done           per-router packet_done; only the owner's bit is used
//   grant          registered one-hot grant
//   grant_valid    high while any grant bit is high
//   grant_id       index of the current owner, 0 when idle
//   timeout_pulse  one-cycle pulse after a grant is revoked by timeout
//   timeout_count  saturating count of timeouts
module rr_channel_arbiter #(
  parameter int NUM_ROUTERS  = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 16,
  parameter int IDW          = $clog2(NUM_ROUTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ROUTERS-1:0] request,
  input  logic [NUM_ROUTERS-1:0] done,
  output logic [NUM_ROUTERS-1:0] grant,
  output logic                   grant_valid,
  output logic [IDW-1:0]         grant_id,
  output logic                   timeout_pulse,
  output logic [15:0]            timeout_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;

  logic [1:0]     state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [15:0]    hold_cnt_q;
  logic [15:0]    guard_cnt_q;

  // Circular search from rr_ptr. Walking offsets from high to low lets the
  // smallest offset with a set request overwrite the others.
  logic           pick_found;
  logic [IDW-1:0] pick_id;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = NUM_ROUTERS - 1; i >= 0; i--) begin
      int s;
      s = int'(rr_ptr_q) + i;
      if (s >= NUM_ROUTERS) s = s - NUM_ROUTERS;
      if (request[s]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(s);
      end
    end
  end

  // Release decision for the current owner; done outranks abort outranks
  // timeout, so only a timeout with the request still up and no done counts.
  logic owner_done, owner_req, hold_hit, release_now, is_timeout;
  logic [IDW-1:0] next_ptr;

  always_comb begin
    owner_done  = done[grant_id];
    owner_req   = request[grant_id];
    hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == 16'(MAX_HOLD - 1));
    release_now = owner_done || !owner_req || hold_hit;
    is_timeout  = hold_hit && owner_req && !owner_done;
    next_ptr    = (grant_id == IDW'(NUM_ROUTERS - 1)) ? '0 : grant_id + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
      guard_cnt_q   <= '0;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant       <= NUM_ROUTERS'(1) << pick_id;
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            hold_cnt_q  <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt_q <= hold_cnt_q + 16'd1;
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr_q    <= next_ptr;
            guard_cnt_q <= '0;
            state_q     <= (GUARD_CYCLES > 0) ? GUARD : IDLE;
            if (is_timeout) begin
              timeout_pulse <= 1'b1;
              if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            end
          end
        end
        GUARD: begin
          guard_cnt_q <= guard_cnt_q + 16'd1;
          if (guard_cnt_q == 16'(GUARD_CYCLES - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Bench for rr_channel_arbiter: directed scenarios plus random traffic, all
// checked against a cycle-level reference model of the channel ownership.
module tb_rr_channel_arbiter;
  localparam int N   = 4;
  localparam int G   = 2;
  localparam int MH  = 16;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   request = '0;
  logic [N-1:0]   done = '0;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout_pulse;
  logic [15:0]    timeout_count;

  always #5 clk = ~clk;

  rr_channel_arbiter #(.NUM_ROUTERS(N), .GUARD_CYCLES(G), .MAX_HOLD(MH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .request(request), .done(done), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_pulse(timeout_pulse),
    .timeout_count(timeout_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the channel, for how many cycles, how many
  // blocked cycles remain after a release, and where the next search starts.
  int m_owner = -1, m_age = 0, m_gap = 0, m_ptr = 0, m_cnt = 0;
  bit m_tp = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0; m_cnt = 0; m_tp = 1'b0;
    end else begin
      m_tp = 1'b0;
      if (m_owner >= 0) begin
        m_age++;
        if (done[m_owner] || !request[m_owner] || (MH != 0 && m_age == MH)) begin
          if (!done[m_owner] && request[m_owner]) begin
            m_tp = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = G;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int i = 0; i < N; i++)
          if (m_owner < 0 && request[(m_ptr + i) % N]) begin
            m_owner = (m_ptr + i) % N;
            m_age   = 0;
          end
      end
    end
  end

  // Continuous comparison against the model plus the one-hot invariant.
  logic [N-1:0] exp_g;
  int           exp_id;
  always @(negedge clk) begin
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    exp_id = (m_owner >= 0) ? m_owner : 0;
    vectors++;
    if (grant !== exp_g || grant_valid !== (m_owner >= 0) || grant_id !== IDW'(exp_id) ||
        timeout_pulse !== m_tp || timeout_count !== 16'(m_cnt)) begin
      miscompares++;
      $display("FAIL model t=%0t: grant=%b valid=%b id=%0d tp=%b cnt=%h, required grant=%b id=%0d tp=%b cnt=%h",
               $time, grant, grant_valid, grant_id, timeout_pulse, timeout_count, exp_g, exp_id, m_tp, 16'(m_cnt));
    end
    vectors++;
    if (!$onehot0(grant)) begin
      miscompares++;
      $display("FAIL onehot t=%0t: grant=%b, required at most one bit", $time, grant);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; request = '0; done = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; request = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout_count !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_state c%0d: grant=%b valid=%b cnt=%h, required 0000/0/0000", c, grant, grant_valid, timeout_count);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_grant: grant=%b, required 0001", grant);
    end
  endtask

  task automatic test_basic_grant();
    do_reset();
    request = 4'b1010;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_grant: grant=%b id=%0d, required 0010 id 1", grant, grant_id);
    end
    done = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      done = '0;
      vectors++;
      if (grant !== 4'b0000) begin
        miscompares++;
        $display("FAIL guard_gap c%0d: grant=%b, required 0000", c, grant);
      end
    end
    @(negedge clk);
    vectors++;
    if (grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL after_guard: grant=%b, required 1000", grant);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] e;
      int t;
      t = 0;
      while (!grant_valid && t < 20) begin @(negedge clk); t++; end
      e = '0; e[k % N] = 1'b1;
      vectors++;
      if (grant !== e) begin
        miscompares++;
        $display("FAIL rotation k%0d: grant=%b, required %b", k, grant, e);
      end
      repeat (2) @(negedge clk);
      done = grant;
      @(negedge clk);
      done = '0;
    end
  endtask

  task automatic test_timeout();
    int hi, lo;
    do_reset();
    request = 4'b0100;
    @(negedge clk);
    hi = 0;
    while (grant_valid && hi < 40) begin hi++; @(negedge clk); end
    vectors++;
    if (hi != 16 || timeout_pulse !== 1'b1 || timeout_count !== 16'd1) begin
      miscompares++;
      $display("FAIL timeout: held=%0d tp=%b cnt=%h, required 16/1/0001", hi, timeout_pulse, timeout_count);
    end
    lo = 0;
    while (!grant_valid && lo < 20) begin lo++; @(negedge clk); end
    vectors++;
    if (lo != 3 || grant !== 4'b0100 || timeout_pulse !== 1'b0 || timeout_count !== 16'd1) begin
      miscompares++;
      $display("FAIL timeout_regrant: gap=%0d grant=%b tp=%b cnt=%h, required 3/0100/0/0001", lo, grant, timeout_pulse, timeout_count);
    end
  endtask

  task automatic test_ignore_and_abort();
    do_reset();
    request = 4'b0010;
    @(negedge clk);
    done = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      done = '0;
      vectors++;
      if (grant !== 4'b0010) begin
        miscompares++;
        $display("FAIL foreign_done c%0d: grant=%b, required 0010", c, grant);
      end
    end
    request = '0;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000 || timeout_count !== 16'd0 || timeout_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: grant=%b cnt=%h tp=%b, required 0000/0000/0", grant, timeout_count, timeout_pulse);
    end
  endtask

  task automatic test_saturation_and_reset();
    int t;
    do_reset();
    @(posedge clk);
    #1;
    force dut.timeout_count = 16'hFFFE;
    m_cnt = 65534;
    #1;
    release dut.timeout_count;
    request = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!timeout_pulse && t < 40) begin @(negedge clk); t++; end
      vectors++;
      if (timeout_pulse !== 1'b1 || timeout_count !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL saturate k%0d: tp=%b cnt=%h, required 1/FFFF", k, timeout_pulse, timeout_count);
      end
      @(negedge clk);
    end
    t = 0;
    while (!grant_valid && t < 20) begin @(negedge clk); t++; end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant !== 4'b0000 || timeout_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: grant=%b cnt=%h, required 0000/0000", grant, timeout_count);
    end
    rst = 1'b0; request = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) request = N'($urandom);
      done = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      rst  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; request = '0; done = '0;
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_rotation();
    test_timeout();
    test_ignore_and_abort();
    test_saturation_and_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
